rf_cmd_master: RTL and testbench
================================

Name: rf_cmd_master

Overview:
UART-side command initiator for the register file. It parses byte frames from the UART receiver, issues single-cycle write and read strobes on the register file port, and returns read data to the TX-side FIFO. It sits between the UART RX data-sync output and the register file address/WrEn/RdEn port.

Parameters:
DATA_WIDTH, 8, width of RX bytes, register data and TX data
ADDR_WIDTH, 4, register file address width; address is the low ADDR_WIDTH bits of the address byte
WR_CMD, 8'hAA, frame opcode for a register write
RD_CMD, 8'hBB, frame opcode for a register read
TIMEOUT_CYCLES, 1024, inter-byte timeout in CLK cycles; used only with RF_CMD_TIMEOUT_EN

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte
RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA is valid this cycle
address  output  ADDR_WIDTH  register file address
WrEn  output  1  register file write strobe
RdEn  output  1  register file read strobe
WrData  output  DATA_WIDTH  register file write data
RdData  input  DATA_WIDTH  register file read data
RdData_valid  input  1  read data valid, one cycle after RdEn
TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  output  1  one-cycle FIFO write strobe
FIFO_FULL  input  1  TX FIFO full; no push while high
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. On reset (RST low, any state, mid-frame included): address=0, WrEn=0, RdEn=0, WrData=0, TX_P_DATA=0, TX_D_VLD=0, busy=0, FSM=IDLE, partial frame discarded.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE: on RX_D_VLD with RX_P_DATA==WR_CMD -> WR_ADDR; ==RD_CMD -> RD_ADDR; any other byte is ignored and the FSM stays in IDLE.
- WR_ADDR: on RX_D_VLD, latch the address -> WR_DATA.
- WR_DATA: on RX_D_VLD, latch WrData -> WR_EXEC.
- WR_EXEC: WrEn=1 for exactly one cycle, with address/WrData stable -> IDLE.
- RD_ADDR: on RX_D_VLD, latch the address -> RD_EXEC.
- RD_EXEC: RdEn=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: on RdData_valid, capture RdData into TX_P_DATA -> TX_SEND.
- TX_SEND: if FIFO_FULL=0, TX_D_VLD=1 for one cycle -> IDLE. If FIFO_FULL=1, hold TX_P_DATA and wait, with no timeout.
- Latency with data byte at cycle N: WrEn is high in N+1. With address byte at N: RdEn is high in N+1, RdData_valid in N+2, TX_D_VLD in N+3 (not full).
- WrEn and RdEn are never high together. Neither is high for more than one consecutive cycle.
- RX_D_VLD pulses in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND are dropped. They never start a new frame.
- An opcode byte received in WR_ADDR, WR_DATA or RD_ADDR is treated as payload, not as a resync.
- address and WrData hold their last values when idle.
- Address bits above ADDR_WIDTH are truncated, with no error.

Optional Feature:
- Macro: RF_CMD_TIMEOUT_EN.
- Defined: an inter-byte counter runs in WR_ADDR, WR_DATA and RD_ADDR and clears on each RX_D_VLD. When it reaches TIMEOUT_CYCLES with no byte, the FSM returns to IDLE with no strobe issued. The counter is reset to 0.
- Undefined: there is no counter, and partial frames wait indefinitely.

Test Plan:
- Reset: assert RST=0 mid-WR_DATA, then release -> all outputs 0, FSM in IDLE, and the next frame AA,01,55 writes 0x55 to address 1.
- Write frame AA,05,3C -> one-cycle WrEn with address=5, WrData=0x3C, one cycle after the 3C pulse; RdEn stays 0.
- Read frame BB,02 with register model returning 0x21 -> RdEn one cycle, then TX_D_VLD one cycle with TX_P_DATA=0x21, 3 cycles after the 02 byte.
- Read with FIFO_FULL=1 for 10 cycles -> TX_D_VLD stays 0 and busy=1, TX_P_DATA is held; TX_D_VLD pulses once the cycle after FIFO_FULL drops.
- Garbage 0x11, then AA,13,7E -> 0x11 is ignored; write to address 3 (truncated from 0x13) with data 0x7E; an extra RX byte during WR_EXEC is dropped.
- With RF_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send AA,04, then idle 16 cycles -> FSM returns to IDLE with no WrEn, and a following BB,04 completes a read normally.

Source files
------------

// File: rtl/rf_cmd_master.sv
// UART-side frame parser driving register file write/read strobes and TX FIFO pushes.
// Optional inter-byte timeout: define RF_CMD_TIMEOUT_EN.
module rf_cmd_master #(
    parameter int              DATA_WIDTH     = 8,
    parameter int              ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD   = 8'hBB,
    parameter int              TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [DATA_WIDTH-1:0] txd_n;
    logic                  wr_n;
    logic                  rd_n;
    logic                  txv_n;
    logic                  unused_bits;

    assign unused_bits = ^RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

`ifdef RF_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state == WR_ADDR) || (state == WR_DATA) ||
                     (state == RD_ADDR);
    assign tmo_hit = waiting && !RX_D_VLD && (cnt == LIMIT);

    always_comb begin
        cnt_n = '0;
        if (waiting && !RX_D_VLD && !tmo_hit) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_n = state;
        addr_n  = address;
        wdata_n = WrData;
        txd_n   = TX_P_DATA;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        txv_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_n = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_n = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_n = RX_P_DATA;
                    wr_n    = 1'b1;
                    state_n = WR_EXEC;
                end
            end
            WR_EXEC: state_n = IDLE;
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_n    = 1'b1;
                    state_n = RD_EXEC;
                end
            end
            RD_EXEC: state_n = RD_WAIT;
            RD_WAIT: begin
                if (RdData_valid) begin
                    txd_n   = RdData;
                    txv_n   = !FIFO_FULL;
                    state_n = TX_SEND;
                end
            end
            TX_SEND: begin
                // Push is pre-registered, so leave once it is on the wire.
                if (TX_D_VLD) begin
                    state_n = IDLE;
                end else begin
                    txv_n = !FIFO_FULL;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef RF_CMD_TIMEOUT_EN
        if (tmo_hit) begin
            state_n = IDLE;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            address   <= addr_n;
            WrData    <= wdata_n;
            TX_P_DATA <= txd_n;
            WrEn      <= wr_n;
            RdEn      <= rd_n;
            TX_D_VLD  <= txv_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_rf_cmd_master.sv
// Directed bench for rf_cmd_master with a small register file model.
// Build with RF_CMD_TIMEOUT_EN to include the timeout scenario.
module tb_rf_cmd_master;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [3:0] address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData = '0;
    logic       RdData_valid = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       FIFO_FULL = 1'b0;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int viol = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic [7:0] mem [16];

    always #5 CLK = ~CLK;

    rf_cmd_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD(RX_D_VLD),
        .address(address),
        .WrEn(WrEn),
        .RdEn(RdEn),
        .WrData(WrData),
        .RdData(RdData),
        .RdData_valid(RdData_valid),
        .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD),
        .FIFO_FULL(FIFO_FULL),
        .busy(busy)
    );

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    end

    // Register file model: write on WrEn, read data one cycle after RdEn.
    always @(posedge CLK) begin
        if (WrEn) mem[address] <= WrData;
        RdData_valid <= RdEn;
        if (RdEn) RdData <= mem[address];
        if ((WrEn && RdEn) || (WrEn && prev_wr) || (RdEn && prev_rd))
            viol <= viol + 1;
        prev_wr <= WrEn;
        prev_rd <= RdEn;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // After the data byte: WrEn is high in this cycle only.
    task automatic expect_write(input string tag, input logic [3:0] a,
                                input logic [7:0] d);
        check({tag, "_wren"}, WrEn, 1);
        check({tag, "_rden"}, RdEn, 0);
        check({tag, "_addr"}, address, a);
        check({tag, "_wdata"}, WrData, d);
        @(negedge CLK);
        check({tag, "_wren_off"}, WrEn, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic read_frame(input string tag, input logic [3:0] a,
                              input logic [7:0] d);
        send(8'hBB);
        send({4'h0, a});
        check({tag, "_rden"}, RdEn, 1);
        check({tag, "_wren"}, WrEn, 0);
        @(negedge CLK);
        check({tag, "_rden_off"}, RdEn, 0);
        check({tag, "_txv_early"}, TX_D_VLD, 0);
        @(negedge CLK);
        check({tag, "_txv"}, TX_D_VLD, 1);
        check({tag, "_txd"}, TX_P_DATA, d);
        @(negedge CLK);
        check({tag, "_txv_off"}, TX_D_VLD, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        check("rst_addr", address, 0);
        check("rst_wren", WrEn, 0);
        check("rst_rden", RdEn, 0);
        check("rst_txv", TX_D_VLD, 0);
        check("rst_busy", busy, 0);
        RST = 1'b1;
        idle(2);

        // Reset mid-WR_DATA discards the partial frame.
        send(8'hAA);
        send(8'h09);
        check("mid_busy", busy, 1);
        check("mid_addr", address, 9);
        RST = 1'b0;
        #1;
        check("rst2_addr", address, 0);
        check("rst2_busy", busy, 0);
        check("rst2_wdata", WrData, 0);
        idle(2);
        RST = 1'b1;
        idle(1);
        send(8'hAA);
        send(8'h01);
        send(8'h55);
        expect_write("wr1", 4'h1, 8'h55);
        check("mem1", mem[1], 8'h55);

        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        expect_write("wr5", 4'h5, 8'h3C);
        check("hold_addr", address, 5);
        check("hold_wdata", WrData, 8'h3C);

        send(8'hAA);
        send(8'h02);
        send(8'h21);
        expect_write("wr2", 4'h2, 8'h21);
        read_frame("rd2", 4'h2, 8'h21);

        // FIFO back-pressure holds the push.
        send(8'hAA);
        send(8'h07);
        send(8'h9C);
        expect_write("wr7", 4'h7, 8'h9C);
        FIFO_FULL = 1'b1;
        send(8'hBB);
        send(8'h07);
        check("ff_rden", RdEn, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("ff_txv_hold", TX_D_VLD, 0);
            check("ff_busy", busy, 1);
        end
        check("ff_txd_hold", TX_P_DATA, 8'h9C);
        FIFO_FULL = 1'b0;
        @(negedge CLK);
        check("ff_txv", TX_D_VLD, 1);
        check("ff_txd", TX_P_DATA, 8'h9C);
        @(negedge CLK);
        check("ff_txv_off", TX_D_VLD, 0);
        check("ff_idle", busy, 0);

        // Garbage ignored, address truncated, byte in WR_EXEC dropped.
        send(8'h11);
        check("garb_idle", busy, 0);
        send(8'hAA);
        send(8'h13);
        send(8'h7E);
        RX_P_DATA = 8'hBB;
        RX_D_VLD  = 1'b1;
        expect_write("wr3", 4'h3, 8'h7E);
        RX_D_VLD  = 1'b0;
        idle(1);
        check("drop_idle", busy, 0);
        check("mem3", mem[3], 8'h7E);

        // Opcode byte as payload.
        send(8'hAA);
        send(8'hAA);
        send(8'hBB);
        expect_write("wrA", 4'hA, 8'hBB);

`ifdef RF_CMD_TIMEOUT_EN
        send(8'hAA);
        send(8'h04);
        send(8'hC4);
        expect_write("wr4", 4'h4, 8'hC4);
        send(8'hAA);
        send(8'h04);
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            check("tmo_no_wren", WrEn, 0);
        end
        check("tmo_idle", busy, 0);
        read_frame("rd4", 4'h4, 8'hC4);
`endif

        idle(2);
        check("strobe_rules", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
